prbs_checker: RTL and testbench
===============================

PRBS_CHECKER -- requirements
Module: prbs_checker

Interface
REQ-001 Parameter BIT_PERIOD, default 16, clock cycles per received bit (min 4).
REQ-002 Parameter SYNC_BITS, default 32, consecutive predicted-bit matches required to declare lock.
REQ-003 Parameter LOSS_ERRS, default 8, bit errors within one 128-bit window that force loss of lock.
REQ-004 Parameter CNT_W, default 24, width of the bit and error counters.
REQ-005 CLK  input  1  system clock, all logic on its rising edge.
REQ-006 i_Reset  input  1  asynchronous, active-high reset.
REQ-007 i_ReceivedSignal  input  1  asynchronous photodiode bit stream, carrying PRBS7 when the link is up.
REQ-008 i_ClearCounts  input  1  synchronous clear of o_BitCount and o_ErrCount.
REQ-009 o_Locked  output  1  high while in LOCKED state.
REQ-010 o_SampleStrobe  output  1  one-cycle pulse per bit sample.
REQ-011 o_BitErr  output  1  one-cycle pulse per mismatched bit while locked.
REQ-012 o_BitCount  output  CNT_W  bits checked while locked, saturating.
REQ-013 o_ErrCount  output  CNT_W  errored bits while locked, saturating.

Function
REQ-014 The block SHALL pass i_ReceivedSignal through a 2-flop synchronizer; only the synchronized bit rx_s is used downstream.
REQ-015 A phase counter SHALL count 0..BIT_PERIOD-1 and wrap; o_SampleStrobe SHALL pulse, and rx_s SHALL be sampled, when the counter equals BIT_PERIOD/2.
REQ-016 Predicted bit SHALL be sr[6] XOR sr[5] of a 7-bit shift register sr (polynomial x^7+x^6+1).
REQ-017 The FSM SHALL have exactly two states: SEARCH and LOCKED.
REQ-018 In SEARCH, each sample SHALL shift the received bit into sr.
REQ-019 In SEARCH, a match counter SHALL increment on a match with sr nonzero, and SHALL clear on a mismatch or when sr is zero.
REQ-020 SEARCH->LOCKED SHALL occur on the sample at which the match counter reaches SYNC_BITS; the match counter then clears.
REQ-021 A stuck-low input (sr all zero) SHALL never declare lock.
REQ-022 In LOCKED, each sample SHALL shift the predicted bit, not the received bit, into sr (free-running reference).
REQ-023 In LOCKED, a mismatch SHALL pulse o_BitErr and increment o_ErrCount; every sample SHALL increment o_BitCount.
REQ-024 In LOCKED, the window counter SHALL count samples 0..127; an in-window error counter SHALL clear at wrap.
REQ-025 Reaching LOSS_ERRS errors within one window SHALL force LOCKED->SEARCH on that sample.
REQ-026 On that sample, o_BitErr and the counts SHALL still update, and the match and window counters SHALL clear.
REQ-027 o_Locked, o_BitErr and the counters SHALL update on the clock edge following the cycle in which o_SampleStrobe is high; latency from input pin to o_BitErr SHALL be at most BIT_PERIOD/2+3 cycles.
REQ-028 Counters SHALL saturate at 2^CNT_W-1, not wrap.
REQ-029 i_ClearCounts SHALL zero both counters on the next edge; clear SHALL win over a simultaneous increment.
REQ-030 i_ClearCounts SHALL NOT affect the FSM or sr.

Reset
REQ-031 On i_Reset high, immediately and independent of CLK, all of the following SHALL be cleared: synchronizer flops 0, phase counter 0, sr 0, FSM SEARCH, all internal counters 0, all outputs 0.
REQ-032 Reset asserted mid-lock SHALL drop o_Locked at once; after release, a full SYNC_BITS reacquisition SHALL be required.

Configuration
REQ-033 With PRBS_CHECKER_EDGE_ALIGN_EN defined, any transition of rx_s SHALL reload the phase counter to 0, so sampling stays mid-bit despite transmitter clock drift.
REQ-034 Without PRBS_CHECKER_EDGE_ALIGN_EN, the phase counter SHALL free-run from reset.

Verification
REQ-035 BIT_PERIOD=4, clean PRBS7 input, edge align on: o_Locked rises after exactly 32 nonzero-state matching samples; o_ErrCount stays 0.
REQ-036 Input held 0 for 500 bits: o_Locked stays 0; o_BitCount=0.
REQ-037 Locked, then 3 single-bit inversions 20 bits apart: exactly 3 o_BitErr pulses, o_ErrCount=3, o_Locked stays 1.
REQ-038 Locked, then 8 inversions within 128 bits: o_Locked falls on the 8th errored sample; o_ErrCount=8; relock occurs after 32 clean bits.
REQ-039 CNT_W=4, locked 20 bits: o_BitCount=15; i_ClearCounts coinciding with a sample yields 0.
REQ-040 i_Reset pulsed mid-lock between clock edges: all outputs 0 before the next edge.

Source files
------------

// File: rtl/prbs_checker.sv
// PRBS7 (x^7+x^6+1) receive checker: synchronizes an asynchronous bit stream, samples mid-bit,
// locks to the sequence and counts bit errors. Define PRBS_CHECKER_EDGE_ALIGN_EN to re-phase sampling on data edges.
module prbs_checker #(
    parameter int BIT_PERIOD = 16,
    parameter int SYNC_BITS  = 32,
    parameter int LOSS_ERRS  = 8,
    parameter int CNT_W      = 24
) (
    input  logic             CLK,
    input  logic             i_Reset,
    input  logic             i_ReceivedSignal,
    input  logic             i_ClearCounts,
    output logic             o_Locked,
    output logic             o_SampleStrobe,
    output logic             o_BitErr,
    output logic [CNT_W-1:0] o_BitCount,
    output logic [CNT_W-1:0] o_ErrCount
);

    localparam int PH_W = $clog2(BIT_PERIOD);
    localparam int MT_W = $clog2(SYNC_BITS + 1);
    localparam int LE_W = $clog2(LOSS_ERRS + 1);

    localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(BIT_PERIOD - 1);
    localparam logic [PH_W-1:0]  PH_MID    = PH_W'(BIT_PERIOD / 2);
    localparam logic [PH_W-1:0]  PH_ONE    = PH_W'(1);
    localparam logic [MT_W-1:0]  MT_LAST   = MT_W'(SYNC_BITS - 1);
    localparam logic [MT_W-1:0]  MT_ONE    = MT_W'(1);
    localparam logic [LE_W-1:0]  LE_LIMIT  = LE_W'(LOSS_ERRS);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [6:0]       WIN_LAST  = 7'd127;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    logic             sync1_q, sync2_q;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic [6:0]       sr_q, sr_d;
    state_t           state_q, state_d;
    logic [MT_W-1:0]  match_q, match_d;
    logic [6:0]       win_q, win_d;
    logic [LE_W-1:0]  win_err_q, win_err_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             bit_err_q, bit_err_d;

    logic             rx_s;
    logic             sample;
    logic             pred;
    logic             mismatch;
    logic             bit_inc;
    logic             err_inc;
    logic [LE_W-1:0]  errs_now;

    assign rx_s     = sync2_q;
    assign sample   = (phase_q == PH_MID);
    assign pred     = sr_q[6] ^ sr_q[5];
    assign mismatch = (rx_s != pred);
    assign errs_now = win_err_q + LE_W'(mismatch);

`ifdef PRBS_CHECKER_EDGE_ALIGN_EN
    logic rx_prev_q;
    logic rx_edge;

    assign rx_edge = rx_s ^ rx_prev_q;

    always_ff @(posedge CLK or posedge i_Reset) begin
        if (i_Reset) begin
            rx_prev_q <= 1'b0;
        end else begin
            rx_prev_q <= rx_s;
        end
    end
`endif

    always_comb begin
        phase_d   = (phase_q == PH_LAST) ? '0 : phase_q + PH_ONE;
`ifdef PRBS_CHECKER_EDGE_ALIGN_EN
        // Re-phase on every data transition so the sample point tracks transmitter drift.
        if (rx_edge) begin
            phase_d = '0;
        end
`endif
        sr_d      = sr_q;
        state_d   = state_q;
        match_d   = match_q;
        win_d     = win_q;
        win_err_d = win_err_q;
        bit_err_d = 1'b0;
        bit_inc   = 1'b0;
        err_inc   = 1'b0;

        if (sample) begin
            case (state_q)
                SEARCH: begin
                    sr_d = {sr_q[5:0], rx_s};
                    // An all-zero register predicts zero forever, so it never earns credit.
                    if (!mismatch && (sr_q != 7'd0)) begin
                        if (match_q == MT_LAST) begin
                            state_d   = LOCKED;
                            match_d   = '0;
                            win_d     = '0;
                            win_err_d = '0;
                        end else begin
                            match_d = match_q + MT_ONE;
                        end
                    end else begin
                        match_d = '0;
                    end
                end
                LOCKED: begin
                    sr_d      = {sr_q[5:0], pred};
                    bit_inc   = 1'b1;
                    err_inc   = mismatch;
                    bit_err_d = mismatch;
                    if (errs_now >= LE_LIMIT) begin
                        state_d   = SEARCH;
                        match_d   = '0;
                        win_d     = '0;
                        win_err_d = '0;
                    end else begin
                        win_d     = win_q + 7'd1;
                        win_err_d = (win_q == WIN_LAST) ? '0 : errs_now;
                    end
                end
                default: begin
                    state_d = SEARCH;
                end
            endcase
        end

        bit_cnt_d = bit_cnt_q;
        err_cnt_d = err_cnt_q;
        if (i_ClearCounts) begin
            bit_cnt_d = '0;
            err_cnt_d = '0;
        end else begin
            if (bit_inc && (bit_cnt_q != '1)) begin
                bit_cnt_d = bit_cnt_q + CNT_ONE;
            end
            if (err_inc && (err_cnt_q != '1)) begin
                err_cnt_d = err_cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge CLK or posedge i_Reset) begin
        if (i_Reset) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            phase_q   <= '0;
            sr_q      <= '0;
            state_q   <= SEARCH;
            match_q   <= '0;
            win_q     <= '0;
            win_err_q <= '0;
            bit_cnt_q <= '0;
            err_cnt_q <= '0;
            bit_err_q <= 1'b0;
        end else begin
            sync1_q   <= i_ReceivedSignal;
            sync2_q   <= sync1_q;
            phase_q   <= phase_d;
            sr_q      <= sr_d;
            state_q   <= state_d;
            match_q   <= match_d;
            win_q     <= win_d;
            win_err_q <= win_err_d;
            bit_cnt_q <= bit_cnt_d;
            err_cnt_q <= err_cnt_d;
            bit_err_q <= bit_err_d;
        end
    end

    assign o_Locked       = (state_q == LOCKED);
    assign o_SampleStrobe = sample;
    assign o_BitErr       = bit_err_q;
    assign o_BitCount     = bit_cnt_q;
    assign o_ErrCount     = err_cnt_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: a bit-level reference model tracks every cycle, plus a vector table
// and directed sequences for lock, loss, saturation, clear and asynchronous reset.
module tb_prbs_checker;

    localparam int BP   = 4;
    localparam int SYNC = 32;
    localparam int LOSS = 8;
    localparam int CW   = 24;
    localparam int CW4  = 4;
    localparam int MAXREQ = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pin = 1'b0;
    logic clr = 1'b0;

    logic           locked, strobe, biterr;
    logic [CW-1:0]  bc, ec;
    logic           locked4, strobe4, biterr4;
    logic [CW4-1:0] bc4, ec4;

    prbs_checker #(.BIT_PERIOD(BP), .SYNC_BITS(SYNC), .LOSS_ERRS(LOSS), .CNT_W(CW)) dut (
        .CLK(clk), .i_Reset(rst), .i_ReceivedSignal(pin), .i_ClearCounts(clr),
        .o_Locked(locked), .o_SampleStrobe(strobe), .o_BitErr(biterr),
        .o_BitCount(bc), .o_ErrCount(ec)
    );

    prbs_checker #(.BIT_PERIOD(BP), .SYNC_BITS(SYNC), .LOSS_ERRS(LOSS), .CNT_W(CW4)) dut4 (
        .CLK(clk), .i_Reset(rst), .i_ReceivedSignal(pin), .i_ClearCounts(clr),
        .o_Locked(locked4), .o_SampleStrobe(strobe4), .o_BitErr(biterr4),
        .o_BitCount(bc4), .o_ErrCount(ec4)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (lives entirely in the monitor process) ----------------
    int checks = 0;
    int errors = 0;
    int rst_cnt = 0;
    int rst_seen = 0;
    logic h1 = 1'b0, h2 = 1'b0;

    bit m_locked, m_biterr;
    int m_match, m_win, m_werr, m_bc, m_ec;
    bit m_ref[$];
    int gap;
    bit have_strobe;

    // directed expectations posted by the stimulus, evaluated by the monitor
    string  req_name[MAXREQ];
    int     req_sel[MAXREQ];
    longint req_exp[MAXREQ];
    longint req_act[MAXREQ];
    int     req_n = 0;
    int     req_done = 0;

    always @(posedge rst) rst_cnt++;

    // two-stage delay of the pin, i.e. the synchronized bit as the checker sees it
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            h1 = 1'b0;
            h2 = 1'b0;
        end else begin
            h2 = h1;
            h1 = pin;
        end
    end

    function automatic logic [63:0] sat(int v, int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (longint'(v) > mx) ? mx : longint'(v);
    endfunction

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_locked = 0; m_biterr = 0;
        m_match = 0; m_win = 0; m_werr = 0; m_bc = 0; m_ec = 0;
        m_ref = {};
        repeat (7) m_ref.push_back(1'b0);
        gap = 0; have_strobe = 0;
    endfunction

    // One received bit: history queue holds the last 7 reference bits, oldest first.
    function automatic void model_step(bit rx);
        bit pred, nz, err;
        pred = m_ref[0] ^ m_ref[1];
        nz = 0;
        foreach (m_ref[k]) nz |= m_ref[k];
        if (!m_locked) begin
            m_ref.push_back(rx);
            if (rx == pred && nz) begin
                m_match++;
                if (m_match == SYNC) begin
                    m_locked = 1; m_match = 0; m_win = 0; m_werr = 0;
                end
            end else begin
                m_match = 0;
            end
        end else begin
            m_ref.push_back(pred);
            m_bc++;
            err = (rx != pred);
            m_biterr = err;
            if (err) begin
                m_ec++;
                m_werr++;
            end
            if (m_werr >= LOSS) begin
                m_locked = 0; m_match = 0; m_win = 0; m_werr = 0;
            end else begin
                m_win++;
                if (m_win == 128) begin
                    m_win = 0; m_werr = 0;
                end
            end
        end
        void'(m_ref.pop_front());
    endfunction

    function automatic logic [63:0] observe(int sel, longint given);
        case (sel)
            0: return 64'(locked);
            1: return 64'(bc);
            2: return 64'(ec);
            3: return 64'(biterr);
            4: return 64'(strobe);
            5: return 64'(locked4);
            6: return 64'(bc4);
            7: return 64'(ec4);
            default: return given;
        endcase
    endfunction

    always @(negedge clk) begin
        if (rst || rst_cnt != rst_seen) begin
            model_reset();
            rst_seen = rst_cnt;
        end
        check("locked", locked, m_locked);
        check("bit_err", biterr, m_biterr);
        check("bit_count", bc, sat(m_bc, CW));
        check("err_count", ec, sat(m_ec, CW));
        check("locked_w4", locked4, m_locked);
        check("bit_err_w4", biterr4, m_biterr);
        check("bit_count_w4", bc4, sat(m_bc, CW4));
        check("err_count_w4", ec4, sat(m_ec, CW4));
        if (rst) check("strobe_in_reset", strobe, 0);
        while (req_done < req_n) begin
            check(req_name[req_done], observe(req_sel[req_done], req_act[req_done]), req_exp[req_done]);
            req_done++;
        end
        if (!rst) begin
            m_biterr = 0;
            gap++;
            if (strobe) begin
                if (have_strobe) begin
`ifdef PRBS_CHECKER_EDGE_ALIGN_EN
                    check("strobe_gap_in_range", 64'(gap >= BP/2 + 1 && gap <= 2*BP), 1);
`else
                    check("strobe_gap", gap, BP);
`endif
                end
                have_strobe = 1;
                gap = 0;
                model_step(h2);
            end
            if (clr) begin
                m_bc = 0;
                m_ec = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    bit g_hist[$];

    task automatic expect_now(string name, int sel, longint exp, longint act = 0);
        if (req_n < MAXREQ) begin
            req_name[req_n] = name;
            req_sel[req_n]  = sel;
            req_exp[req_n]  = exp;
            req_act[req_n]  = act;
            req_n++;
        end
    endtask

    // b[n] = b[n-7] ^ b[n-6]
    function automatic bit prbs_next();
        bit b;
        b = g_hist[0] ^ g_hist[1];
        g_hist.push_back(b);
        void'(g_hist.pop_front());
        return b;
    endfunction

    task automatic send_bit(input logic b, input logic c);
        @(posedge clk); #2;
        pin = b;
        clr = c;
        @(posedge clk); #2;
        clr = 1'b0;
        repeat (BP - 2) @(posedge clk);
    endtask

    task automatic send_prbs(input int n);
        repeat (n) send_bit(prbs_next(), 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst = 1'b1;
        pin = 1'b0;
        @(posedge clk); #2;
        rst = 1'b0;
    endtask

    typedef struct {
        int clean_bits;
        int n_inv;
        int gap_bits;
        bit exp_locked;
        int exp_err;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int seed;
        bit found;
        int burst;
        bit inv;
        bit c;

        vecs[0] = '{clean_bits: 45, n_inv: 0, gap_bits: 1,  exp_locked: 1'b1, exp_err: 0};
        vecs[1] = '{clean_bits: 45, n_inv: 3, gap_bits: 20, exp_locked: 1'b1, exp_err: 3};
        vecs[2] = '{clean_bits: 45, n_inv: 7, gap_bits: 12, exp_locked: 1'b1, exp_err: 7};
        vecs[3] = '{clean_bits: 45, n_inv: 8, gap_bits: 10, exp_locked: 1'b0, exp_err: 8};
        vecs[4] = '{clean_bits: 45, n_inv: 8, gap_bits: 1,  exp_locked: 1'b0, exp_err: 8};
        vecs[5] = '{clean_bits: 20, n_inv: 0, gap_bits: 1,  exp_locked: 1'b0, exp_err: 0};

        seed = $urandom_range(1, 127);
        for (int i = 0; i < 7; i++) g_hist.push_back(seed[i]);

        // reset state
        expect_now("reset_locked", 0, 0);
        expect_now("reset_bit_count", 1, 0);
        expect_now("reset_err_count", 2, 0);
        expect_now("reset_bit_err", 3, 0);
        expect_now("reset_strobe", 4, 0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        // stuck-low input never locks
        repeat (500) send_bit(1'b0, 1'b0);
        expect_now("stuck_low_locked", 0, 0);
        expect_now("stuck_low_bit_count", 1, 0);

        // clean PRBS locks with no errors
        send_prbs(60);
        expect_now("clean_locked", 0, 1);
        expect_now("clean_err_count", 2, 0);

        // narrow counter saturates
        send_prbs(20);
        expect_now("sat_bit_count_w4", 6, 15);

        // clear landing on a sample edge wins over the increment
        found = 0;
        for (int i = 0; i < 2 * BP && !found; i++) begin
            @(posedge clk); #2;
            if (strobe) found = 1;
        end
        if (found) begin
            clr = 1'b1;
            @(posedge clk); #2;
            clr = 1'b0;
        end
        expect_now("clear_found_strobe", 9, 1, longint'(found));
        expect_now("clear_bit_count", 1, 0);
        expect_now("clear_err_count", 2, 0);
        expect_now("clear_bit_count_w4", 6, 0);
        expect_now("clear_locked", 0, 1);

        // asynchronous reset between edges while locked
        send_prbs(40);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        expect_now("async_rst_locked", 0, 0);
        expect_now("async_rst_strobe", 4, 0);
        expect_now("async_rst_bit_err", 3, 0);
        expect_now("async_rst_bit_count", 1, 0);
        expect_now("async_rst_err_count", 2, 0);
        expect_now("async_rst_locked_w4", 5, 0);
        @(negedge clk); #1;
        rst = 1'b0;
        send_prbs(20);
        expect_now("reacq_not_yet", 0, 0);
        send_prbs(40);
        expect_now("reacq_locked", 0, 1);

        // table of lock / error-injection scenarios
        for (int v = 0; v < 6; v++) begin
            do_reset();
            send_prbs(vecs[v].clean_bits);
            for (int j = 0; j < vecs[v].n_inv; j++) begin
                send_bit(~prbs_next(), 1'b0);
                send_prbs(vecs[v].gap_bits - 1);
            end
            send_prbs(3);
            expect_now($sformatf("vec%0d_locked", v), 0, longint'(vecs[v].exp_locked));
            expect_now($sformatf("vec%0d_err_count", v), 2, longint'(vecs[v].exp_err));
        end

        // random errors, bursts, dropouts and clears against the model
        do_reset();
        burst = 0;
        for (int i = 0; i < 900; i++) begin
            if (burst > 0) begin
                inv = 1;
                burst--;
            end else begin
                inv = ($urandom_range(0, 49) == 0);
                if ($urandom_range(0, 299) == 0) burst = $urandom_range(4, 12);
            end
            if ($urandom_range(0, 399) == 0) repeat (20) send_bit(1'b0, 1'b0);
            c = ($urandom_range(0, 79) == 0);
            send_bit(prbs_next() ^ inv, c);
        end

        repeat (3) @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
